// File: rtl/mdu_iter_if.sv
// Handshake bundle between the core and the iterative multiply/divide unit.
//   master (core side): drives start, flush, funct3, rs1_val, rs2_val, rd_addr
//                       and observes busy, done, result, rd_out, we_out.
//   slave  (MDU side) : the mirror image.
interface mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_addr;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            we_out;

  modport master (
    output start, flush, funct3, rs1_val, rs2_val, rd_addr,
    input  busy, done, result, rd_out, we_out
  );

  modport slave (
    input  start, flush, funct3, rs1_val, rs2_val, rd_addr,
    output busy, done, result, rd_out, we_out
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus.start/flush/funct3/rs1_val/rs2_val/rd_addr : request from decode/RF read
//   bus.busy   : high from accept until the done cycle, stalls fetch/PC
//   bus.done   : one-cycle pulse, result/rd_out valid
//   bus.result/rd_out : held until the next completed operation
//   bus.we_out : done && rd_out != 0, feeds WE3 of the register file
// Flow: IDLE -> CALC (XLEN shift-add / restoring shift-subtract steps)
//       -> FIXUP (sign correction, half/quotient/remainder select) -> DONE.
// Divide-by-zero and signed overflow resolve at accept and go straight to DONE.
// Optional macro MDU_FAST_MUL_EN: MUL* uses a single-cycle multiplier and
// goes IDLE -> FIXUP; divides are unaffected.
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       rst_n,
  mdu_iter_if.slave bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_w(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [4:0]        rd_lat;
  logic [XLEN-1:0]   opb;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;      // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [XLEN-1:0]   res;
  logic              q_neg;    // product / quotient must be negated
  logic              r_neg;    // remainder must be negated

  // Accept-time decode
  logic signed [XLEN-1:0] a_s, b_s;
  logic [2:0]      f;
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;

  assign f   = bus.funct3;
  assign a_s = bus.rs1_val;
  assign b_s = bus.rs2_val;

  always_comb begin
    is_div   = f[2];
    a_signed = (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
    b_signed = (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    a_neg    = a_signed && (a_s < 0);
    b_neg    = b_signed && (b_s < 0);
    // Negating -2^(XLEN-1) wraps to itself, which is the correct unsigned magnitude.
    mag_a    = cneg(bus.rs1_val, a_neg);
    mag_b    = cneg(bus.rs2_val, b_neg);
    div_zero = is_div && (bus.rs2_val == '0);
    div_ovf  = is_div && !f[0] && (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);
    special  = div_zero || div_ovf;
    if (div_zero) spec_res = f[1] ? bus.rs1_val : '1;
    else          spec_res = f[1] ? '0 : MIN_NEG;
    accept   = (state == S_IDLE) && bus.start && !bus.flush;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
`endif

  // Iteration step
  logic [XLEN:0]     mul_sum, div_diff;
  logic              qbit;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_diff = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opb};
    qbit     = ~div_diff[XLEN];
    div_next = {(qbit ? div_diff[XLEN-1:0] : {acc[2*XLEN-2:XLEN], acc[XLEN-1]}),
                acc[XLEN-2:0], qbit};
  end

  // Fixup: sign correction and field select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    prod = cneg_w(acc, q_neg);
    quo  = cneg(acc[XLEN-1:0], q_neg);
    rem  = cneg(acc[2*XLEN-1:XLEN], r_neg);
    if (op[2])            fix_res = op[1] ? rem : quo;
    else if (op == 3'd0)  fix_res = prod[XLEN-1:0];
    else                  fix_res = prod[2*XLEN-1:XLEN];
  end

  // Datapath registers: no reset, only meaningful after an accept
  always_ff @(posedge clk) begin
    if (accept) begin
      op     <= f;
      rd_lat <= bus.rd_addr;
      opb    <= mag_b;
      q_neg  <= a_neg ^ b_neg;
      r_neg  <= a_neg;
      res    <= spec_res;
`ifdef MDU_FAST_MUL_EN
      acc    <= is_div ? {{XLEN{1'b0}}, mag_a} : fast_prod;
`else
      acc    <= {{XLEN{1'b0}}, mag_a};
`endif
    end else if (state == S_CALC) begin
      acc <= op[2] ? div_next : mul_next;
    end else if (state == S_FIXUP) begin
      res <= fix_res;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.we_out <= 1'b0;
      bus.result <= '0;
      bus.rd_out <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.we_out <= 1'b0;
      if (bus.flush && state != S_IDLE) begin
        state    <= S_IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              bus.busy <= 1'b1;
              cnt      <= '0;
`ifdef MDU_FAST_MUL_EN
              state    <= special ? S_DONE : (is_div ? S_CALC : S_FIXUP);
`else
              state    <= special ? S_DONE : S_CALC;
`endif
            end
          end
          S_CALC: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN - 1)) state <= S_FIXUP;
          end
          S_FIXUP: state <= S_DONE;
          S_DONE: begin
            state      <= S_IDLE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.we_out <= (rd_lat != 5'd0);
            bus.result <= res;
            bus.rd_out <= rd_lat;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
  localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if #(.XLEN(XLEN)) bus();
  mdu_iter #(.XLEN(XLEN), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [2:0]  d_f [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a [12] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                            32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'd2, 32'd2,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_e [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                            32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  // Reference: RV32M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    if (!f[2] && FAST) return 2;
    return 34;
  endfunction

  // Issue one op and observe: latency in cycles after accept edge (-1 on timeout),
  // outputs in the done cycle, busy high before done and low at done, single-cycle pulse.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output int lat, output logic [31:0] res, output logic [4:0] rdo, output logic we,
                        output logic busy_ok, output logic pulse_ok);
    bus.funct3 = f; bus.rs1_val = a; bus.rs2_val = b; bus.rd_addr = rd; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rs1_val = $urandom; bus.rs2_val = $urandom; bus.rd_addr = 5'($urandom);
    lat = -1; res = '0; rdo = '0; we = 1'b0; busy_ok = 1'b1; pulse_ok = 1'b1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k; res = bus.result; rdo = bus.rd_out; we = bus.we_out;
        if (bus.busy) busy_ok = 1'b0;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      if (bus.done) pulse_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.we_out !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.we_out); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
    checks++; if (bus.rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", bus.rd_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat, lat_e; logic [31:0] res; logic [4:0] rdo; logic we, bok, pok;
    for (int i = 0; i < 12; i++) begin
      run_op(d_f[i], d_a[i], d_b[i], 5'(i + 5), lat, res, rdo, we, bok, pok);
      lat_e = (i >= 8) ? 1 : ((i < 4 && FAST) ? 2 : 34);
      checks++; if (res !== d_e[i]) begin errors++; $display("FAIL dir_result[%0d]: got %h want %h", i, res, d_e[i]); end
      checks++; if (lat != lat_e) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, lat_e); end
      checks++; if (rdo !== 5'(i + 5)) begin errors++; $display("FAIL dir_rd[%0d]: got %0d want %0d", i, rdo, i + 5); end
      checks++; if (we !== 1'b1) begin errors++; $display("FAIL dir_we[%0d]: got %b want 1", i, we); end
      checks++; if (!bok) begin errors++; $display("FAIL dir_busy[%0d]: got bad busy window want high until done", i); end
      checks++; if (!pok) begin errors++; $display("FAIL dir_pulse[%0d]: got done 2 cycles want 1", i); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res, a, b, e; logic [4:0] rdo, rd; logic [2:0] f; logic we, bok, pok;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: b = 32'd0;
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        4: b = 32'($signed(5'($urandom)));
        default: begin a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF; b = 32'h7FFFFFFF; end
      endcase
      rd = 5'($urandom);
      e = ref_model(f, a, b);
      run_op(f, a, b, rd, lat, res, rdo, we, bok, pok);
      checks++; if (res !== e) begin errors++; $display("FAIL rnd_result[%0d] f=%0d a=%h b=%h: got %h want %h", i, f, a, b, res, e); end
      checks++; if (lat != exp_lat(f, a, b)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, exp_lat(f, a, b)); end
      checks++; if (rdo !== rd || we !== (rd != 0)) begin errors++; $display("FAIL rnd_rd_we[%0d]: got rd=%0d we=%b want rd=%0d we=%b", i, rdo, we, rd, rd != 0); end
      checks++; if (!bok || !pok) begin errors++; $display("FAIL rnd_handshake[%0d]: got busy_ok=%b pulse_ok=%b want 1 1", i, bok, pok); end
    end
  endtask

  task automatic test_rd_zero();
    int lat; logic [31:0] res; logic [4:0] rdo; logic we, bok, pok;
    run_op(3'd0, 32'd3, 32'd4, 5'd0, lat, res, rdo, we, bok, pok);
    checks++; if (lat < 0) begin errors++; $display("FAIL rd0_done: got timeout want done"); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rd0_we: got %b want 0", we); end
    checks++; if (res !== 32'd12 || rdo !== 5'd0) begin errors++; $display("FAIL rd0_result: got %h/%0d want 0000000c/0", res, rdo); end
  endtask

  task automatic test_start_busy();
    int lat; int seen;
    bus.funct3 = 3'd5; bus.rs1_val = 32'd1000; bus.rs2_val = 32'd3; bus.rd_addr = 5'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      if (k == 4) begin bus.funct3 = 3'd0; bus.rs1_val = 32'd6; bus.rs2_val = 32'd7; bus.rd_addr = 5'd3; bus.start = 1'b1; end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) lat = k;
    end
    checks++; if (lat != 34) begin errors++; $display("FAIL busy_start_latency: got %0d want 34", lat); end
    checks++; if (bus.result !== 32'd333 || bus.rd_out !== 5'd9) begin errors++; $display("FAIL busy_start_result: got %h/%0d want 0000014d/9", bus.result, bus.rd_out); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (bus.done || bus.busy) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL busy_start_queued: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_flush();
    int lat, seen; logic [31:0] res; logic [4:0] rdo; logic we, bok, pok;
    run_op(3'd0, 32'd11, 32'd13, 5'd4, lat, res, rdo, we, bok, pok);
    checks++; if (res !== 32'd143) begin errors++; $display("FAIL flush_prior: got %h want 0000008f", res); end
    bus.funct3 = 3'd4; bus.rs1_val = 32'd77; bus.rs2_val = 32'd5; bus.rd_addr = 5'd6; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    seen = 0;
    for (int k = 0; k < 45; k++) begin if (bus.done || bus.we_out) seen++; @(posedge clk); #1; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_done: got %0d done cycles want 0", seen); end
    checks++; if (bus.result !== 32'd143 || bus.rd_out !== 5'd4) begin errors++; $display("FAIL flush_hold: got %h/%0d want 0000008f/4", bus.result, bus.rd_out); end
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin if (bus.done || bus.busy) seen++; @(posedge clk); #1; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_idle_start: got %0d active cycles want 0", seen); end
    run_op(3'd5, 32'd100, 32'd7, 5'd2, lat, res, rdo, we, bok, pok);
    checks++; if (res !== 32'd14 || lat != 34) begin errors++; $display("FAIL flush_recover: got %h lat %0d want 0000000e lat 34", res, lat); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res, e; logic [4:0] rdo; logic we, bok, pok;
    bus.funct3 = 3'd7; bus.rs1_val = 32'd12345; bus.rs2_val = 32'd17; bus.rd_addr = 5'd8; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.we_out !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got busy=%b done=%b we=%b want 0 0 0", bus.busy, bus.done, bus.we_out); end
    checks++; if (bus.result !== 32'd0 || bus.rd_out !== 5'd0) begin errors++; $display("FAIL midrst_data: got %h/%0d want 0/0", bus.result, bus.rd_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    e = ref_model(3'd3, 32'hDEADBEEF, 32'h12345678);
    run_op(3'd3, 32'hDEADBEEF, 32'h12345678, 5'd31, lat, res, rdo, we, bok, pok);
    checks++; if (res !== e || rdo !== 5'd31 || we !== 1'b1) begin errors++; $display("FAIL midrst_next: got %h/%0d/%b want %h/31/1", res, rdo, we, e); end
    checks++; if (lat != exp_lat(3'd3, 32'hDEADBEEF, 32'h12345678)) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", lat, exp_lat(3'd3, 32'hDEADBEEF, 32'h12345678)); end
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
    bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_addr = 5'd0;
    test_reset();
    test_directed();
    test_random();
    test_rd_zero();
    test_start_busy();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
